// File: rtl/map_tile_store.sv
// 21x21 tile map: built-in layout loaded after reset, combinational read port,
// request/acknowledge write port and a running count of orb tiles.
module map_tile_store #(
  parameter int MAP_W = 21,
  parameter int MAP_H = 21
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic [4:0] rd_x,
  input  logic [4:0] rd_y,
  output logic [2:0] rd_sprite_type,
  input  logic       wr_req,
  input  logic [4:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [2:0] wr_sprite_type,
  output logic       wr_ack,
  output logic       wr_err,
  output logic       init_done,
  output logic [8:0] orbs_remaining,
  output logic       level_clear
);

  localparam int         CELLS     = MAP_W * MAP_H;
  localparam logic [4:0] X_MAX     = 5'(MAP_W - 1);
  localparam logic [4:0] Y_MAX     = 5'(MAP_H - 1);
  localparam logic [8:0] COUNT_MAX = 9'(CELLS);

  typedef enum logic [1:0] {INIT, IDLE, ACK} state_t;

  state_t     state;
  logic [4:0] init_x;
  logic [4:0] init_y;
  logic [2:0] tiles [0:CELLS-1];

  function automatic logic is_orb(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010);
  endfunction

  function automatic logic [8:0] cell_index(input logic [4:0] x, input logic [4:0] y);
    return 9'(y) * 9'(MAP_W) + 9'(x);
  endfunction

  // Border walls win, then the even/even pillar grid, then the four corner big orbs.
  function automatic logic [2:0] layout(input logic [4:0] x, input logic [4:0] y);
    logic [2:0] t;
    if (x == 5'd0 || x == X_MAX || y == 5'd0 || y == Y_MAX)
      t = 3'b011;
    else if (!x[0] && !y[0])
      t = 3'b100;
    else if ((x == 5'd1 || x == X_MAX - 5'd1) && (y == 5'd1 || y == Y_MAX - 5'd1))
      t = 3'b001;
    else
      t = 3'b010;
    return t;
  endfunction

  logic       rd_in_range;
  logic       wr_in_range;
  logic [8:0] rd_idx;
  logic [8:0] wr_idx;
  logic [8:0] init_idx;
  logic [2:0] init_tile;
  logic [2:0] wr_old;
  logic [8:0] count_next;

  assign rd_in_range = (rd_x <= X_MAX) && (rd_y <= Y_MAX);
  assign wr_in_range = (wr_x <= X_MAX) && (wr_y <= Y_MAX);
  assign rd_idx      = rd_in_range ? cell_index(rd_x, rd_y) : 9'd0;
  assign wr_idx      = wr_in_range ? cell_index(wr_x, wr_y) : 9'd0;
  assign init_idx    = cell_index(init_x, init_y);
  assign init_tile   = layout(init_x, init_y);
  assign wr_old      = tiles[wr_idx];

  always_comb begin
    rd_sprite_type = 3'b000;
    if (!init_done)
      rd_sprite_type = 3'b000;
    else if (!rd_in_range)
      rd_sprite_type = 3'b100;
    else
      rd_sprite_type = tiles[rd_idx];
  end

  // Orb count after a candidate write, saturating at both ends.
  always_comb begin
    count_next = orbs_remaining;
    if (is_orb(wr_old) && !is_orb(wr_sprite_type) && orbs_remaining != 9'd0)
      count_next = orbs_remaining - 9'd1;
    else if (!is_orb(wr_old) && is_orb(wr_sprite_type) && orbs_remaining != COUNT_MAX)
      count_next = orbs_remaining + 9'd1;
    else
      count_next = orbs_remaining;
  end

  always_ff @(posedge clock_50) begin
    if (!reset) begin
      if (state == INIT)
        tiles[init_idx] <= init_tile;
      else if (state == IDLE && wr_req && wr_in_range)
        tiles[wr_idx] <= wr_sprite_type;
    end
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state          <= INIT;
      init_x         <= 5'd0;
      init_y         <= 5'd0;
      orbs_remaining <= 9'd0;
      init_done      <= 1'b0;
      wr_ack         <= 1'b0;
      wr_err         <= 1'b0;
      level_clear    <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          wr_ack      <= 1'b0;
          wr_err      <= 1'b0;
          level_clear <= 1'b0;
          if (is_orb(init_tile) && orbs_remaining != COUNT_MAX)
            orbs_remaining <= orbs_remaining + 9'd1;
          if (init_x == X_MAX) begin
            init_x <= 5'd0;
            if (init_y == Y_MAX) begin
              init_y    <= 5'd0;
              state     <= IDLE;
              init_done <= 1'b1;
            end else begin
              init_y <= init_y + 5'd1;
            end
          end else begin
            init_x <= init_x + 5'd1;
          end
        end
        IDLE: begin
          if (wr_req) begin
            state  <= ACK;
            wr_ack <= 1'b1;
            if (wr_in_range) begin
              wr_err         <= 1'b0;
              orbs_remaining <= count_next;
              level_clear    <= (orbs_remaining == 9'd1) && (count_next == 9'd0);
            end else begin
              wr_err      <= 1'b1;
              level_clear <= 1'b0;
            end
          end else begin
            wr_ack      <= 1'b0;
            wr_err      <= 1'b0;
            level_clear <= 1'b0;
          end
        end
        ACK: begin
          state       <= IDLE;
          wr_ack      <= 1'b0;
          wr_err      <= 1'b0;
          level_clear <= 1'b0;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_tile_store.sv
// Scoreboard bench for map_tile_store: stimulus pushes expected write responses,
// a negedge monitor pops and compares them whenever wr_ack is seen.
module tb_map_tile_store;

  logic       clock_50 = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] rd_x = 5'd0, rd_y = 5'd0;
  logic [2:0] rd_sprite_type;
  logic       wr_req = 1'b0;
  logic [4:0] wr_x = 5'd0, wr_y = 5'd0;
  logic [2:0] wr_sprite_type = 3'b000;
  logic       wr_ack, wr_err, init_done, level_clear;
  logic [8:0] orbs_remaining;

  map_tile_store dut (
    .clock_50(clock_50), .reset(reset),
    .rd_x(rd_x), .rd_y(rd_y), .rd_sprite_type(rd_sprite_type),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_sprite_type(wr_sprite_type),
    .wr_ack(wr_ack), .wr_err(wr_err), .init_done(init_done),
    .orbs_remaining(orbs_remaining), .level_clear(level_clear)
  );

  always #10 clock_50 = ~clock_50;

  typedef struct {
    logic err;
    logic lc;
    int   cnt;
  } exp_t;

  exp_t       sb[$];
  int         compared = 0;
  int         mismatched = 0;
  int         lc_pulses = 0;
  logic [2:0] mdl [0:440];
  int         mcount;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit orb(input logic [2:0] v);
    return v == 3'b001 || v == 3'b010;
  endfunction

  // Hand-written layout: walls on the rim, pillars at even/even, big orbs in the four inner corners.
  task automatic model_rebuild();
    mcount = 0;
    for (int y = 0; y < 21; y++)
      for (int x = 0; x < 21; x++) begin
        if (x == 0 || y == 0 || x == 20 || y == 20)       mdl[y*21+x] = 3'b011;
        else if (x % 2 == 0 && y % 2 == 0)                mdl[y*21+x] = 3'b100;
        else if ((x == 1 || x == 19) && (y == 1 || y == 19)) mdl[y*21+x] = 3'b001;
        else                                              mdl[y*21+x] = 3'b010;
        if (orb(mdl[y*21+x])) mcount++;
      end
  endtask

  task automatic predict(input int x, input int y, input logic [2:0] v);
    exp_t e;
    int   prev;
    prev = mcount;
    e.err = 1'b0;
    e.lc = 1'b0;
    if (x > 20 || y > 20) begin
      e.err = 1'b1;
    end else begin
      if (orb(mdl[y*21+x]) && !orb(v) && mcount > 0) mcount--;
      else if (!orb(mdl[y*21+x]) && orb(v) && mcount < 441) mcount++;
      mdl[y*21+x] = v;
      e.lc = (prev == 1 && mcount == 0);
    end
    e.cnt = mcount;
    sb.push_back(e);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clock_50) begin
    if (level_clear) begin
      lc_pulses++;
      check("level_clear_with_ack", int'(wr_ack), 1);
    end
    if (wr_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_err", int'(wr_err), int'(e.err));
        check("level_clear", int'(level_clear), int'(e.lc));
        check("orbs_after_write", int'(orbs_remaining), e.cnt);
      end
    end
  end

  task automatic do_write(input int x, input int y, input logic [2:0] v);
    bit got;
    predict(x, y, v);
    wr_x = 5'(x);
    wr_y = 5'(y);
    wr_sprite_type = v;
    wr_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clock_50);
      #1;
      got = wr_ack;
    end
    if (!got) check("ack_timeout", 0, 1);
    wr_req = 1'b0;
    @(posedge clock_50);
    #1;
  endtask

  task automatic rd_check(input string name, input int x, input int y, input int exp);
    rd_x = 5'(x);
    rd_y = 5'(y);
    #1;
    check(name, int'(rd_sprite_type), exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock_50);
    @(posedge clock_50);
    #1;
    reset = 1'b0;
    model_rebuild();
  endtask

  task automatic run_init();
    for (int i = 0; i < 440; i++) begin
      @(posedge clock_50);
      #1;
      if (i == 0) rd_check("rd_during_init", 1, 1, 0);
    end
    check("init_done_before_last", int'(init_done), 0);
    @(posedge clock_50);
    #1;
    check("init_done_after_441", int'(init_done), 1);
    check("orbs_after_init", int'(orbs_remaining), 280);
  endtask

  initial begin
    // 1: reset and initial layout
    do_reset();
    check("reset_orbs", int'(orbs_remaining), 0);
    check("reset_init_done", int'(init_done), 0);
    check("reset_wr_ack", int'(wr_ack), 0);
    run_init();
    rd_check("rd_0_5", 0, 5, 3);
    rd_check("rd_2_2", 2, 2, 4);
    rd_check("rd_1_1", 1, 1, 1);
    rd_check("rd_3_1", 3, 1, 2);
    rd_check("rd_25_3", 25, 3, 4);
    rd_check("rd_19_19", 19, 19, 1);
    rd_check("rd_20_20", 20, 20, 3);

    // 2: orb cleared then restored
    do_write(3, 1, 3'b000);
    rd_check("rd_3_1_cleared", 3, 1, 0);
    check("orbs_279", int'(orbs_remaining), 279);
    do_write(3, 1, 3'b010);
    rd_check("rd_3_1_restored", 3, 1, 2);
    check("orbs_280", int'(orbs_remaining), 280);

    // 3: out-of-range write and wall->black write
    do_write(21, 4, 3'b000);
    rd_check("rd_20_4_intact", 20, 4, 3);
    do_write(0, 0, 3'b000);
    rd_check("rd_0_0_black", 0, 0, 0);
    check("orbs_wall_write", int'(orbs_remaining), 280);
    do_write(7, 7, 3'b110);
    rd_check("rd_7_7_verbatim", 7, 7, 6);
    check("orbs_279_after_110", int'(orbs_remaining), 279);

    // 4: wr_req held high, acks every other cycle
    wr_x = 5'd5;
    wr_y = 5'd1;
    wr_sprite_type = 3'b000;
    for (int k = 0; k < 4; k++) predict(5, 1, 3'b000);
    wr_req = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock_50);
      #1;
      check("held_ack_pattern", int'(wr_ack), k % 2);
    end
    wr_req = 1'b0;
    @(posedge clock_50);
    #1;
    check("orbs_after_hold", int'(orbs_remaining), 278);

    // 5: clear every remaining orb
    lc_pulses = 0;
    for (int y = 0; y < 21; y++)
      for (int x = 0; x < 21; x++)
        if (orb(mdl[y*21+x])) do_write(x, y, 3'b000);
    check("orbs_zero", int'(orbs_remaining), 0);
    check("level_clear_pulses", lc_pulses, 1);
    do_write(4, 1, 3'b000);
    check("orbs_saturate_zero", int'(orbs_remaining), 0);

    // 6a: reset in the middle of init
    do_reset();
    repeat (200) @(posedge clock_50);
    #1;
    do_reset();
    check("midinit_reset_orbs", int'(orbs_remaining), 0);
    run_init();
    rd_check("rebuilt_3_1", 3, 1, 2);

    // 6b: reset during ACK
    predict(1, 3, 3'b000);
    wr_x = 5'd1;
    wr_y = 5'd3;
    wr_sprite_type = 3'b000;
    wr_req = 1'b1;
    @(posedge clock_50);
    #1;
    check("ack_before_reset", int'(wr_ack), 1);
    wr_req = 1'b0;
    reset = 1'b1;
    @(posedge clock_50);
    #1;
    reset = 1'b0;
    model_rebuild();
    check("ack_dropped_by_reset", int'(wr_ack), 0);
    check("init_done_dropped", int'(init_done), 0);
    run_init();
    rd_check("rebuilt_1_3", 1, 3, 2);

    repeat (4) @(posedge clock_50);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/map_tile_store.md
Name: map_tile_store

Overview:
Owns the 21x21 tile map that the display scan reads and the game logic modifies. It serves a combinational read port (coordinates in, sprite_type out) for the map display scan. A request/acknowledge write port lets game logic overwrite tiles, for example to clear an orb once eaten. After reset it fills the map from a fixed built-in layout and tracks the number of remaining orbs.

Parameters:
MAP_W, 21, map width in tiles (x = 0..MAP_W-1)
MAP_H, 21, map height in tiles (y = 0..MAP_H-1)

Ports:
clock_50  input  1  system clock
reset  input  1  reset, synchronous, active-high
rd_x  input  5  read tile x
rd_y  input  5  read tile y
rd_sprite_type  output  3  tile at (rd_x, rd_y), combinational
wr_req  input  1  write request, held high until wr_ack
wr_x  input  5  write tile x
wr_y  input  5  write tile y
wr_sprite_type  input  3  new tile value
wr_ack  output  1  one-cycle pulse: write completed or rejected
wr_err  output  1  valid with wr_ack; 1 = out-of-range, no change
init_done  output  1  map initialised, ports live
orbs_remaining  output  9  count of tiles equal to 3'b001 or 3'b010
level_clear  output  1  one-cycle pulse when orbs_remaining goes nonzero -> 0

Behaviour:
- Tile codes: 000 black, 001 big orb, 010 small orb, 011 blue wall, 100 grey wall; 101-111 are stored verbatim.
- Storage: MAP_W*MAP_H x 3-bit register array, indexed by y*MAP_W+x.
- States: INIT, IDLE, ACK.
- Reset (any state, including mid-INIT): state=INIT, init counters x=0,y=0, orbs_remaining=0, init_done=0, wr_ack=0, wr_err=0, level_clear=0.
- INIT: writes one cell per cycle in row-major order, x fastest, starting at (0,0) on the first edge after reset deasserts.
- Layout rule, applied in priority order:
  - border (x==0 or x==20 or y==0 or y==20) -> 011
  - x even and y even -> 100
  - (x,y) in {(1,1),(19,1),(1,19),(19,19)} -> 001
  - otherwise -> 010
- INIT increments orbs_remaining for each orb cell written. Final count is 280 (4 big, 276 small).
- After cell (20,20) is written (441 cycles), state=IDLE and init_done=1 from the next cycle.
- During INIT: rd_sprite_type=000 and wr_req is ignored (no ack).
- Read port: rd_sprite_type = stored cell, zero latency. Out-of-range (rd_x>20 or rd_y>20) returns 100. A write becomes visible on reads the cycle after the accepting edge.
- IDLE, wr_req=1 at an edge:
  - In range: the cell is written at that edge and state=ACK. wr_ack=1 and wr_err=0 for exactly the following cycle.
  - Out of range: no cell change, wr_ack=1 and wr_err=1 the following cycle.
- Orb accounting on an in-range write, where old = stored value and new = wr_sprite_type:
  - old orb, new non-orb: count-1
  - old non-orb, new orb: count+1
  - otherwise: unchanged
  - Count saturates at 0 and at 441.
- level_clear is a 1-cycle pulse, coincident with wr_ack, when a write moves the count from 1 to 0. It is never asserted during INIT.
- ACK: lasts one cycle; wr_req is ignored so the requester can drop it; returns to IDLE. Maximum write throughput is one per 2 cycles.
- A wr_req still high on return to IDLE is treated as a new request.
- wr_x/wr_y/wr_sprite_type are sampled only at the accepting edge.
- Reset during ACK: the pending wr_ack is dropped; the map is rebuilt.

Test Plan:
1. Reset, run 441 cycles -> init_done=1 at cycle 442 and orbs_remaining=280. Reads return (0,5)=011, (2,2)=100, (1,1)=001, (3,1)=010, (25,3)=100; rd_sprite_type=000 before init_done.
2. After init, write (3,1)<-000 -> wr_ack=1/wr_err=0 one cycle later; rd (3,1)=000 next cycle; orbs_remaining=279. Write (3,1)<-010 -> 280.
3. Write (21,4)<-000 -> wr_ack=1, wr_err=1, map unchanged, count 280. Write (0,0)<-000 (wall to black) -> count unchanged.
4. Hold wr_req=1 continuously with fixed data -> acks every 2nd cycle; the count changes only on the first orb->black write.
5. Clear all 280 orb cells -> level_clear pulses exactly once, with the final wr_ack; orbs_remaining=0.
6. Assert reset at init cycle 200 and again during ACK -> init restarts from (0,0), count returns to 280, no stray wr_ack.
